// File: rtl/instr_window_fetcher_pkg.sv
// Shared types and constants for the instruction window fetcher.
package instr_window_fetcher_pkg;

    localparam int unsigned MEM_BYTES_DEF = 1024;
    localparam int unsigned ADDR_W_DEF    = 64;
    localparam int unsigned BYTE_W        = 8;
    localparam int unsigned WORD_W        = 64;
    localparam int unsigned WIN_BYTES     = 10;
    localparam int unsigned WIN_W         = WIN_BYTES * BYTE_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/instr_window_fetcher_window_byte_merge.sv
// Drops the bytes of one aligned memory word into the 10-byte window.
// Window byte i sits at offset (off + i) from the first word; it comes from beat (off + i) / 8.
module window_byte_merge
    import instr_window_fetcher_pkg::*;
(
    input  logic [0:WIN_W-1]  win,
    input  logic [WORD_W-1:0] rdata,
    input  logic [2:0]        off,
    input  logic [1:0]        beat,
    output logic [0:WIN_W-1]  win_out
);

    logic [4:0] pos;

    always_comb begin
        win_out = win;
        pos     = '0;
        for (int i = 0; i < int'(WIN_BYTES); i++) begin
            pos = 5'(off) + 5'(i);
            if (pos[4:3] == beat) begin
                win_out[8*i +: 8] = rdata[{pos[2:0], 3'b000} +: 8];
            end
        end
    end

endmodule

// File: rtl/instr_window_fetcher.sv
// Fetches the 10-byte instruction window at a PC over 2-3 aligned 64-bit memory beats.
// Optional LAST_WORD_REUSE_EN: serve beat 0 from a one-word buffer of the last fetched word.
module instr_window_fetcher
    import instr_window_fetcher_pkg::*;
#(
    parameter int unsigned MEM_BYTES = MEM_BYTES_DEF,
    parameter int unsigned ADDR_W    = ADDR_W_DEF
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_pc,
    output logic              req_ready,
    input  logic              flush,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [63:0]       mem_rdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [0:79]       rsp_instr,
    output logic              rsp_err
);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   w0_q, w0_d;
    logic [2:0]          off_q, off_d;
    logic [1:0]          beat_q, beat_d;
    logic [1:0]          beats_q, beats_d;
    logic                req_ready_d, mem_req_d, rsp_valid_d, rsp_err_d;
    logic [ADDR_W-1:0]   mem_addr_d;
    logic [0:WIN_W-1]    instr_d;
    logic [0:WIN_W-1]    merged_c;
    logic [ADDR_W-1:0]   req_w0_c;
    logic [1:0]          next_beat_c;
    logic [ADDR_W-1:0]   next_addr_c;

    assign req_w0_c    = {req_pc[ADDR_W-1:3], 3'b000};
    assign next_beat_c = beat_q + 2'd1;
    assign next_addr_c = w0_q + ADDR_W'({next_beat_c, 3'b000});

    window_byte_merge u_merge (
        .win     (rsp_instr),
        .rdata   (mem_rdata),
        .off     (off_q),
        .beat    (beat_q),
        .win_out (merged_c)
    );

`ifdef LAST_WORD_REUSE_EN
    logic              tag_valid;
    logic [ADDR_W-1:0] tag_addr;
    logic [63:0]       tag_data;
    logic [0:WIN_W-1]  reuse_win_c;
    logic              reuse_hit_c;

    assign reuse_hit_c = tag_valid && (tag_addr == req_w0_c);

    window_byte_merge u_reuse_merge (
        .win     ('0),
        .rdata   (tag_data),
        .off     (req_pc[2:0]),
        .beat    (2'd0),
        .win_out (reuse_win_c)
    );

    // Remember the last word actually accepted into a window; flush invalidates it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_valid <= 1'b0;
            tag_addr  <= '0;
            tag_data  <= '0;
        end else if (flush) begin
            tag_valid <= 1'b0;
        end else if (state_q == ISSUE && mem_ack) begin
            tag_valid <= 1'b1;
            tag_addr  <= mem_addr;
            tag_data  <= mem_rdata;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            w0_q      <= '0;
            off_q     <= '0;
            beat_q    <= '0;
            beats_q   <= '0;
            req_ready <= 1'b1;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            rsp_valid <= 1'b0;
            rsp_instr <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            w0_q      <= w0_d;
            off_q     <= off_d;
            beat_q    <= beat_d;
            beats_q   <= beats_d;
            req_ready <= req_ready_d;
            mem_req   <= mem_req_d;
            mem_addr  <= mem_addr_d;
            rsp_valid <= rsp_valid_d;
            rsp_instr <= instr_d;
            rsp_err   <= rsp_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        w0_d       = w0_q;
        off_d      = off_q;
        beat_d     = beat_q;
        beats_d    = beats_q;
        mem_addr_d = mem_addr;
        instr_d    = rsp_instr;
        rsp_err_d  = rsp_err;

        case (state_q)
            IDLE: begin
                if (req_valid && !flush) begin
                    instr_d = '0;
                    if (req_pc >= ADDR_W'(MEM_BYTES)) begin
                        rsp_err_d = 1'b1;
                        state_d   = RESP;
                    end else begin
                        rsp_err_d  = 1'b0;
                        w0_d       = req_w0_c;
                        off_d      = req_pc[2:0];
                        beats_d    = (req_pc[2:0] == 3'd7) ? 2'd3 : 2'd2;
                        beat_d     = 2'd0;
                        mem_addr_d = req_w0_c;
                        state_d    = ISSUE;
`ifdef LAST_WORD_REUSE_EN
                        if (reuse_hit_c) begin
                            instr_d = reuse_win_c;
                            beat_d  = 2'd1;
                            if (req_w0_c + ADDR_W'(8) >= ADDR_W'(MEM_BYTES)) begin
                                state_d = RESP;
                            end else begin
                                mem_addr_d = req_w0_c + ADDR_W'(8);
                            end
                        end
`endif
                    end
                end
            end
            ISSUE: begin
                if (mem_ack) begin
                    if (flush) begin
                        state_d = IDLE;
                    end else begin
                        instr_d = merged_c;
                        beat_d  = next_beat_c;
                        // Words past the end of memory are never read; their window bytes stay zero.
                        if (next_beat_c == beats_q || next_addr_c >= ADDR_W'(MEM_BYTES)) begin
                            state_d = RESP;
                        end else begin
                            mem_addr_d = next_addr_c;
                        end
                    end
                end else if (flush) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (mem_ack) begin
                    state_d = IDLE;
                end
            end
            RESP: begin
                if (flush || rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        req_ready_d = (state_d == IDLE);
        mem_req_d   = (state_d == ISSUE) || (state_d == DRAIN);
        rsp_valid_d = (state_d == RESP);
    end

endmodule

// File: doc/instr_window_fetcher.md
Name: instr_window_fetcher

Overview:
- Supplies the 80-bit instruction window consumed by the pipeline fetch stage.
- Accepts a fetch PC, reads a 64-bit-wide aligned instruction memory over 2–3 beats, and assembles bytes PC..PC+9 into one window.
- Presents the window with a valid/ready handshake and an address-error flag.
- Sits between the PC-select logic and instruction memory. Supports flush on return / mispredicted jump.

Parameters:
- MEM_BYTES, 1024, instruction memory size in bytes; a valid PC satisfies PC < MEM_BYTES.
- ADDR_W, 64, PC and address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  fetch request present.
- req_pc  in  ADDR_W  byte address of instruction.
- req_ready  out  1  high only in IDLE.
- flush  in  1  cancels any in-progress or held request.
- mem_req  out  1  memory read request; held until mem_ack.
- mem_addr  out  ADDR_W  8-byte-aligned word address (low 3 bits zero).
- mem_ack  in  1  read data valid this cycle; arbitrary latency ≥ 1 cycle.
- mem_rdata  in  64  read data; byte k of the word is mem_rdata[8k+7:8k] (little-endian).
- rsp_valid  out  1  window valid.
- rsp_ready  in  1  consumer accepts window.
- rsp_instr  out  80  window, declared [0:79]; bits [0:7] hold byte PC, [8:15] hold PC+1, …, [72:79] hold PC+9.
- rsp_err  out  1  PC ≥ MEM_BYTES (imem error).

Behaviour:
- Reset (async, rst_n low): state IDLE; req_ready=1 after reset; mem_req=0; mem_addr=0; rsp_valid=0; rsp_instr=0; rsp_err=0; beat counter and window buffer cleared.
- States:
  - IDLE: req_ready=1. On req_valid && !flush, latch PC.
    - If PC ≥ MEM_BYTES: go to RESP with rsp_err=1, rsp_instr all zeros, no memory access.
    - Otherwise: w0 = PC & ~7, off = PC[2:0], beats = (off==7) ? 3 : 2; go to ISSUE.
  - ISSUE: mem_req=1, mem_addr = w0 + 8*beat.
    - On mem_ack: place bytes of mem_rdata that fall in [PC, PC+9] into the window and increment beat.
    - When the next word address is ≥ MEM_BYTES, or beat == beats: go to RESP. Unfetched window bytes stay 0x00 (decode as halt).
  - RESP: rsp_valid=1; rsp_instr and rsp_err held stable until rsp_ready; on rsp_ready go to IDLE.
  - DRAIN: mem_req stays 1 until mem_ack; the data is discarded; then go to IDLE.
- Latency: request accepted in cycle T with single-cycle ack gives rsp_valid at T+3 (2 beats) or T+4 (3 beats). An error response is valid at T+1.
- Flush:
  - In IDLE, flush blocks acceptance.
  - In ISSUE with mem_ack in the same cycle: data is dropped and the block goes to IDLE.
  - In ISSUE without ack: go to DRAIN. A memory transaction is never abandoned mid-handshake.
  - In RESP: rsp_valid drops next cycle, go to IDLE.
  - flush outranks rsp_ready.
- Simultaneous req_valid and flush in IDLE: the request is ignored.
- Address arithmetic is modulo 2^ADDR_W. PC near 2^64 is caught by the MEM_BYTES check before any beat is issued.

Optional Feature:
- LAST_WORD_REUSE_EN
- Defined: a 1-entry buffer holds the address and data of the last word fetched (tag valid bit cleared by reset and flush).
  - If a new request's w0 equals the buffered tag, beat 0 is served from the buffer with no memory access.
  - Latency drops by one beat in that case.
- Undefined: every beat goes to memory; no buffer storage is instantiated.

Decomposition:
- Shared package: state encoding (IDLE, ISSUE, DRAIN, RESP), MEM_BYTES default, byte-lane constant 8, window width 80.
- One natural sub-module: window_byte_merge. It is combinational: inputs are the current window, mem_rdata, off and beat; output is the updated window. It is reused by the reuse-buffer path.

Test Plan:
- req_pc=0x000, memory bytes 0x30,0xF2,0x0A,0,0,0,0,0,0,0,… with ack latency 1 → rsp_instr[0:23]=30F20A, rest 00; rsp_err=0; 2 mem beats at addr 0x000 and 0x008; rsp_valid 3 cycles after accept.
- req_pc=0x007 → 3 beats at 0x000, 0x008, 0x010; rsp_instr[0:7] = byte 7, [72:79] = byte 16.
- req_pc=0x3FE with MEM_BYTES=1024 → beats at 0x3F8 only; bytes 0x3FE,0x3FF present; remaining 8 bytes = 0x00; rsp_err=0.
- req_pc=0x400 → no mem_req; rsp_valid next cycle with rsp_err=1 and rsp_instr=0.
- flush during ISSUE with ack delayed 4 cycles → mem_req held until ack, no rsp_valid, req_ready=1 after the drain.
- rsp_ready held low for 5 cycles → rsp_instr stable and rsp_valid high throughout; then a back-to-back request is accepted the cycle after the handshake.
